// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage and its consumers.
package fetch_pkg;

    localparam int unsigned INSTR_BYTES       = 4;
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        valid;
    } if_id_t;

    // A fetch is legal when the word is aligned and lies fully inside the ROM.
    function automatic logic fetch_legal(input logic [63:0] pc, input logic [63:0] imem_bytes);
        return (pc[1:0] == 2'b00) && ((pc + 64'd3) < imem_bytes);
    endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register with its next-PC selection and fetch legality check.
module fetch_pc_reg
    import fetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC   = 64'd0,
    parameter int unsigned IMEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hold,
    input  logic        stall,
    input  logic        redirect,
    input  logic [63:0] redirect_target,
    output logic [63:0] pc,
    output logic        legal
);

    logic [63:0] pcNext;

    // Legality of the word currently addressed by the PC.
    always_comb begin
        legal = fetch_legal(pc, 64'(IMEM_BYTES));
    end

    // Next-PC selection: a fault freezes everything, a redirect beats a stall,
    // and an illegal fetch leaves the PC parked on the offending address.
    always_comb begin
        pcNext = pc;
        if (hold) begin
            pcNext = pc;
        end else if (redirect) begin
            pcNext = redirect_target;
        end else if (stall || !legal) begin
            pcNext = pc;
        end else begin
            pcNext = pc + 64'(INSTR_BYTES);
        end
    end

    // PC state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc <= RESET_PC;
        end else begin
            pc <= pcNext;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, addresses the instruction ROM and fills the IF/ID register.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC   = 64'd0,
    parameter int unsigned IMEM_BYTES = 1024,
    parameter logic [31:0] NOP_INSTR  = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [63:0] redirect_target,
    output logic [63:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic [63:0] id_pc,
    output logic [31:0] id_instr,
    output logic        id_valid,
    output logic        fetch_fault,
    output logic [31:0] fetch_count
);

    logic [63:0] pc;
    logic        legal;
    logic        accept;
    logic        bubble;
    logic        raiseFault;
    if_id_t      ifId;

    fetch_pc_reg #(
        .RESET_PC   (RESET_PC),
        .IMEM_BYTES (IMEM_BYTES)
    ) u_pc_reg (
        .clk             (clk),
        .reset           (reset),
        .hold            (fetch_fault),
        .stall           (stall),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .pc              (pc),
        .legal           (legal)
    );

    // Decide this cycle's IF/ID action from the priority chain fault > redirect > stall > illegal.
    always_comb begin
        accept     = 1'b0;
        bubble     = 1'b0;
        raiseFault = 1'b0;
        if (fetch_fault || redirect) begin
            bubble = 1'b1;
        end else if (!stall) begin
            if (legal) begin
                accept = 1'b1;
            end else begin
                bubble     = 1'b1;
                raiseFault = 1'b1;
            end
        end
    end

    // IF/ID pipeline register; id_pc is left untouched on a bubble since it is meaningless then.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ifId.pc    <= 64'd0;
            ifId.instr <= NOP_INSTR;
            ifId.valid <= 1'b0;
        end else if (bubble) begin
            ifId.instr <= NOP_INSTR;
            ifId.valid <= 1'b0;
        end else if (accept) begin
            ifId.pc    <= pc;
            ifId.instr <= imem_instr;
            ifId.valid <= 1'b1;
        end
    end

    // Sticky fault flag, cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_fault <= 1'b0;
        end else if (raiseFault) begin
            fetch_fault <= 1'b1;
        end
    end

    // Saturating count of instructions accepted into IF/ID.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_count <= 32'd0;
        end else if (accept && (fetch_count != 32'hFFFF_FFFF)) begin
            fetch_count <= fetch_count + 32'd1;
        end
    end

    assign imem_addr = pc;
    assign id_pc     = ifId.pc;
    assign id_instr  = ifId.instr;
    assign id_valid  = ifId.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage using a behavioural model of the fetch rules.
module tb_fetch_stage;

    localparam int unsigned ROM_BYTES = 1024;
    localparam logic [31:0] NOP       = 32'h0000_0000;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [63:0] redirect_target;
    logic [63:0] imem_addr;
    logic [31:0] imem_instr;
    logic [63:0] id_pc;
    logic [31:0] id_instr;
    logic        id_valid;
    logic        fetch_fault;
    logic [31:0] fetch_count;

    logic [31:0] rom [ROM_BYTES/4];

    int errors;
    int checks;

    logic [63:0] m_pc;
    logic [63:0] m_idpc;
    logic [31:0] m_instr;
    logic        m_valid;
    logic        m_fault;
    logic [31:0] m_count;

    fetch_stage #(
        .RESET_PC   (64'd0),
        .IMEM_BYTES (ROM_BYTES),
        .NOP_INSTR  (NOP)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .imem_addr       (imem_addr),
        .imem_instr      (imem_instr),
        .id_pc           (id_pc),
        .id_instr        (id_instr),
        .id_valid        (id_valid),
        .fetch_fault     (fetch_fault),
        .fetch_count     (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational ROM; out-of-range addresses return a recognisable junk word.
    always_comb begin
        imem_instr = 32'hDEAD_BEEF;
        if (imem_addr < 64'(ROM_BYTES)) imem_instr = rom[imem_addr[9:2]];
    end

    function automatic logic model_legal(input logic [63:0] p);
        return (p % 64'd4 == 64'd0) && (p <= 64'(ROM_BYTES - 4));
    endfunction

    function automatic logic [31:0] model_word(input logic [63:0] p);
        return rom[int'(p / 64'd4)];
    endfunction

    // Flag an unknown ROM word on a legal fetch.
    always @(negedge clk) begin
        if (!reset && !m_fault && model_legal(m_pc))
            assert (!$isunknown(imem_instr)) else $error("[TB] unknown ROM word at %h", m_pc);
    end

    task automatic model_reset();
        m_pc    = 64'd0;
        m_idpc  = 64'd0;
        m_instr = NOP;
        m_valid = 1'b0;
        m_fault = 1'b0;
        m_count = 32'd0;
    endtask

    task automatic model_step();
        if (m_fault) begin
            m_valid = 1'b0;
            m_instr = NOP;
        end else if (redirect) begin
            m_pc    = redirect_target;
            m_valid = 1'b0;
            m_instr = NOP;
        end else if (stall) begin
            m_pc = m_pc;
        end else if (!model_legal(m_pc)) begin
            m_fault = 1'b1;
            m_valid = 1'b0;
            m_instr = NOP;
        end else begin
            m_idpc  = m_pc;
            m_instr = model_word(m_pc);
            m_valid = 1'b1;
            m_pc    = m_pc + 64'd4;
            if (m_count != 32'hFFFF_FFFF) m_count = m_count + 32'd1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        stall = 1'b0;
        redirect = 1'b0;
        model_reset();
        #2;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        model_reset();
        #1;
        checks += 6;
        if (imem_addr !== 64'd0) begin errors++; $display("[TB] FAIL reset_pc: got %h expected 0", imem_addr); end
        if (id_pc !== 64'd0) begin errors++; $display("[TB] FAIL reset_id_pc: got %h expected 0", id_pc); end
        if (id_instr !== NOP) begin errors++; $display("[TB] FAIL reset_id_instr: got %h expected %h", id_instr, NOP); end
        if (id_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_id_valid: got %b expected 0", id_valid); end
        if (fetch_fault !== 1'b0) begin errors++; $display("[TB] FAIL reset_fault: got %b expected 0", fetch_fault); end
        if (fetch_count !== 32'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", fetch_count); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_free_run();
        for (int i = 0; i < 4; i++) begin
            tick();
            checks += 4;
            if (id_pc !== 64'(i * 4)) begin errors++; $display("[TB] FAIL free_id_pc[%0d]: got %h expected %h", i, id_pc, 64'(i * 4)); end
            if (id_instr !== rom[i]) begin errors++; $display("[TB] FAIL free_id_instr[%0d]: got %h expected %h", i, id_instr, rom[i]); end
            if (id_valid !== 1'b1) begin errors++; $display("[TB] FAIL free_id_valid[%0d]: got %b expected 1", i, id_valid); end
            if (imem_addr !== 64'(i * 4 + 4)) begin errors++; $display("[TB] FAIL free_pc[%0d]: got %h expected %h", i, imem_addr, 64'(i * 4 + 4)); end
        end
        checks++;
        if (fetch_count !== 32'd4) begin errors++; $display("[TB] FAIL free_count: got %0d expected 4", fetch_count); end
    endtask

    task automatic test_stall();
        do_reset();
        tick();
        tick();
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks += 4;
            if (imem_addr !== 64'd8) begin errors++; $display("[TB] FAIL stall_pc[%0d]: got %h expected 8", i, imem_addr); end
            if (id_pc !== 64'd4) begin errors++; $display("[TB] FAIL stall_id_pc[%0d]: got %h expected 4", i, id_pc); end
            if (id_instr !== rom[1]) begin errors++; $display("[TB] FAIL stall_id_instr[%0d]: got %h expected %h", i, id_instr, rom[1]); end
            if (fetch_count !== 32'd2) begin errors++; $display("[TB] FAIL stall_count[%0d]: got %0d expected 2", i, fetch_count); end
        end
        stall = 1'b0;
        tick();
        checks += 3;
        if (id_pc !== 64'd8) begin errors++; $display("[TB] FAIL stall_resume_pc: got %h expected 8", id_pc); end
        if (id_instr !== rom[2]) begin errors++; $display("[TB] FAIL stall_resume_instr: got %h expected %h", id_instr, rom[2]); end
        if (fetch_count !== 32'd3) begin errors++; $display("[TB] FAIL stall_resume_count: got %0d expected 3", fetch_count); end
    endtask

    task automatic test_redirect_over_stall();
        stall = 1'b1;
        redirect = 1'b1;
        redirect_target = 64'h40;
        tick();
        stall = 1'b0;
        redirect = 1'b0;
        checks += 3;
        if (imem_addr !== 64'h40) begin errors++; $display("[TB] FAIL redir_pc: got %h expected 40", imem_addr); end
        if (id_valid !== 1'b0) begin errors++; $display("[TB] FAIL redir_flush_valid: got %b expected 0", id_valid); end
        if (id_instr !== NOP) begin errors++; $display("[TB] FAIL redir_flush_instr: got %h expected %h", id_instr, NOP); end
        tick();
        checks += 3;
        if (id_pc !== 64'h40) begin errors++; $display("[TB] FAIL redir_id_pc: got %h expected 40", id_pc); end
        if (id_valid !== 1'b1) begin errors++; $display("[TB] FAIL redir_id_valid: got %b expected 1", id_valid); end
        if (id_instr !== rom[16]) begin errors++; $display("[TB] FAIL redir_id_instr: got %h expected %h", id_instr, rom[16]); end
    endtask

    task automatic test_range_fault();
        redirect = 1'b1;
        redirect_target = 64'h3FC;
        tick();
        redirect = 1'b0;
        tick();
        checks += 3;
        if (id_pc !== 64'h3FC) begin errors++; $display("[TB] FAIL edge_id_pc: got %h expected 3fc", id_pc); end
        if (id_valid !== 1'b1) begin errors++; $display("[TB] FAIL edge_id_valid: got %b expected 1", id_valid); end
        if (fetch_fault !== 1'b0) begin errors++; $display("[TB] FAIL edge_no_fault: got %b expected 0", fetch_fault); end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks += 3;
            if (fetch_fault !== 1'b1) begin errors++; $display("[TB] FAIL range_fault[%0d]: got %b expected 1", i, fetch_fault); end
            if (id_valid !== 1'b0) begin errors++; $display("[TB] FAIL range_valid[%0d]: got %b expected 0", i, id_valid); end
            if (imem_addr !== 64'h400) begin errors++; $display("[TB] FAIL range_pc[%0d]: got %h expected 400", i, imem_addr); end
        end
    endtask

    task automatic test_misaligned_and_async_reset();
        do_reset();
        redirect = 1'b1;
        redirect_target = 64'h6;
        tick();
        redirect = 1'b0;
        checks += 2;
        if (fetch_fault !== 1'b0) begin errors++; $display("[TB] FAIL mis_early_fault: got %b expected 0", fetch_fault); end
        if (imem_addr !== 64'h6) begin errors++; $display("[TB] FAIL mis_pc: got %h expected 6", imem_addr); end
        tick();
        checks += 2;
        if (fetch_fault !== 1'b1) begin errors++; $display("[TB] FAIL mis_fault: got %b expected 1", fetch_fault); end
        if (imem_addr !== 64'h6) begin errors++; $display("[TB] FAIL mis_pc_hold: got %h expected 6", imem_addr); end
        stall = 1'b1;
        redirect = 1'b1;
        redirect_target = 64'h80;
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        checks += 4;
        if (imem_addr !== 64'd0) begin errors++; $display("[TB] FAIL areset_pc: got %h expected 0", imem_addr); end
        if (fetch_fault !== 1'b0) begin errors++; $display("[TB] FAIL areset_fault: got %b expected 0", fetch_fault); end
        if (id_valid !== 1'b0) begin errors++; $display("[TB] FAIL areset_valid: got %b expected 0", id_valid); end
        if (fetch_count !== 32'd0) begin errors++; $display("[TB] FAIL areset_count: got %0d expected 0", fetch_count); end
        @(negedge clk);
        reset = 1'b0;
        stall = 1'b0;
        redirect = 1'b0;
    endtask

    task automatic test_saturate();
        do_reset();
        @(negedge clk);
        force dut.fetch_count = 32'hFFFF_FFFE;
        #1;
        release dut.fetch_count;
        m_count = 32'hFFFF_FFFE;
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (fetch_count !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL saturate: got %h expected ffffffff", fetch_count); end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 300; i++) begin
            if (m_fault && ($urandom_range(0, 3) == 0)) do_reset();
            stall = ($urandom_range(0, 3) == 0);
            redirect = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 5))
                0:       redirect_target = 64'h3F8;
                1:       redirect_target = 64'($urandom_range(0, 1023));
                2:       redirect_target = {$urandom, $urandom};
                default: redirect_target = 64'($urandom_range(0, 255)) * 64'd4;
            endcase
            tick();
            checks += 5;
            if (imem_addr !== m_pc) begin errors++; $display("[TB] FAIL rnd_pc[%0d]: got %h expected %h", i, imem_addr, m_pc); end
            if (id_valid !== m_valid) begin errors++; $display("[TB] FAIL rnd_valid[%0d]: got %b expected %b", i, id_valid, m_valid); end
            if (id_instr !== m_instr) begin errors++; $display("[TB] FAIL rnd_instr[%0d]: got %h expected %h", i, id_instr, m_instr); end
            if (fetch_fault !== m_fault) begin errors++; $display("[TB] FAIL rnd_fault[%0d]: got %b expected %b", i, fetch_fault, m_fault); end
            if (fetch_count !== m_count) begin errors++; $display("[TB] FAIL rnd_count[%0d]: got %0d expected %0d", i, fetch_count, m_count); end
            if (m_valid) begin
                checks++;
                if (id_pc !== m_idpc) begin errors++; $display("[TB] FAIL rnd_id_pc[%0d]: got %h expected %h", i, id_pc, m_idpc); end
            end
        end
        stall = 1'b0;
        redirect = 1'b0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        stall = 1'b0;
        redirect = 1'b0;
        redirect_target = 64'd0;
        for (int i = 0; i < ROM_BYTES / 4; i++) rom[i] = $urandom;
        model_reset();
        test_reset();
        test_free_run();
        test_stall();
        test_redirect_over_stall();
        test_range_fault();
        test_misaligned_and_async_reset();
        test_saturate();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
